// File: rtl/mem_bus_arbiter_if.sv
// Bundles the IFU/LSU request ports and the RAM/IO target ports of the memory bus arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding core/fabric.
interface mem_bus_arbiter_if;
  logic        ifu_req_i;
  logic [31:0] ifu_addr_i;
  logic        ifu_gnt_o;
  logic        ifu_rvalid_o;
  logic [31:0] ifu_rdata_o;
  logic        ifu_err_o;

  logic        lsu_req_i;
  logic [31:0] lsu_addr_i;
  logic        lsu_we_i;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_gnt_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_err_o;

  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;

  logic        io_en_o;
  logic [3:0]  io_we_o;
  logic [15:0] io_addr_o;
  logic [31:0] io_wdata_o;
  logic [31:0] io_rdata_i;
  logic        io_ready_i;

  modport slave (
    input  ifu_req_i, ifu_addr_i,
    output ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, ifu_err_o,
    input  lsu_req_i, lsu_addr_i, lsu_we_i, lsu_be_i, lsu_wdata_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i,
    output io_en_o, io_we_o, io_addr_o, io_wdata_o,
    input  io_rdata_i, io_ready_i
  );

  modport master (
    output ifu_req_i, ifu_addr_i,
    input  ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, ifu_err_o,
    output lsu_req_i, lsu_addr_i, lsu_we_i, lsu_be_i, lsu_wdata_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i,
    input  io_en_o, io_we_o, io_addr_o, io_wdata_o,
    output io_rdata_i, io_ready_i
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin IFU/LSU arbiter sharing one RAM/IO bus: RAM response 3 cycles after grant, IO 3 + wait cycles.
// Requesters are held off (no grant) until the current transaction has returned its response.
module mem_bus_arbiter #(
  parameter int IO_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_arbiter_if.slave   bus
);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_RAM, S_IO, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last_lsu;
  logic        r_owner_lsu;
  logic        r_we;
  logic        r_err;
  logic        r_src_ram;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_io_rdata;
  logic [7:0]  r_cnt;

  logic        w_any_req;
  logic        w_pick_lsu;
  logic        w_grant;
  logic        w_ram_hit;
  logic        w_io_hit;
  logic        w_io_timeout;
  logic        w_ifu_gnt;
  logic        w_lsu_gnt;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_ram_en;
  logic [3:0]  w_ram_we;
  logic [31:0] w_ram_addr;
  logic [31:0] w_ram_wdata;
  logic        w_io_en;
  logic [3:0]  w_io_we;
  logic [15:0] w_io_addr;
  logic [31:0] w_io_wdata;

  // On a tie the port that did not win last time gets the bus.
  assign w_any_req    = bus.ifu_req_i | bus.lsu_req_i;
  assign w_pick_lsu   = bus.lsu_req_i & (~bus.ifu_req_i | ~r_last_lsu);
  assign w_grant      = (r_state == S_IDLE) & w_any_req & ~rst;
  assign w_ram_hit    = (r_addr[31:28] == 4'h0);
  assign w_io_hit     = (r_addr[31:16] == 16'hF000);
  assign w_io_timeout = (r_cnt == 8'(IO_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_ifu_gnt   = 1'b0;
    w_lsu_gnt   = 1'b0;
    w_rvalid    = 1'b0;
    w_rdata     = '0;
    w_ram_en    = 1'b0;
    w_ram_we    = '0;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    w_io_en     = 1'b0;
    w_io_we     = '0;
    w_io_addr   = '0;
    w_io_wdata  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_next    = S_DECODE;
          w_ifu_gnt = ~w_pick_lsu;
          w_lsu_gnt = w_pick_lsu;
        end
      end
      S_DECODE: begin
        if (w_ram_hit)     w_next = S_RAM;
        else if (w_io_hit) w_next = S_IO;
        else               w_next = S_RESP;
      end
      S_RAM: begin
        w_ram_en    = 1'b1;
        w_ram_we    = r_we ? r_be : 4'h0;
        w_ram_addr  = r_addr;
        w_ram_wdata = r_wdata;
        w_next      = S_RESP;
      end
      S_IO: begin
        w_io_en    = 1'b1;
        w_io_we    = r_we ? r_be : 4'h0;
        w_io_addr  = r_addr[15:0];
        w_io_wdata = r_wdata;
        if (bus.io_ready_i || w_io_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        w_rvalid = 1'b1;
        if (r_err || r_we) w_rdata = '0;
        else if (r_src_ram) w_rdata = bus.ram_rdata_i;
        else                w_rdata = r_io_rdata;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Reset silences every strobe in the same cycle so an aborted IO access is dropped cleanly.
    if (rst) begin
      w_rvalid = 1'b0;
      w_ram_en = 1'b0;
      w_ram_we = '0;
      w_ram_addr = '0;
      w_ram_wdata = '0;
      w_io_en = 1'b0;
      w_io_we = '0;
      w_io_addr = '0;
      w_io_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_lsu  <= 1'b1;
      r_owner_lsu <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_src_ram   <= 1'b0;
      r_be        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_io_rdata  <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner_lsu <= w_pick_lsu;
            r_last_lsu  <= w_pick_lsu;
            r_addr      <= w_pick_lsu ? bus.lsu_addr_i : bus.ifu_addr_i;
            r_we        <= w_pick_lsu & bus.lsu_we_i;
            r_be        <= w_pick_lsu ? bus.lsu_be_i : 4'h0;
            r_wdata     <= w_pick_lsu ? bus.lsu_wdata_i : 32'h0;
            r_err       <= 1'b0;
            r_src_ram   <= 1'b0;
            r_io_rdata  <= '0;
            r_cnt       <= '0;
          end
        end
        S_DECODE: begin
          r_src_ram <= w_ram_hit;
          r_err     <= ~w_ram_hit & ~w_io_hit;
        end
        S_IO: begin
          if (bus.io_ready_i) begin
            r_io_rdata <= bus.io_rdata_i;
            r_cnt      <= '0;
          end else if (w_io_timeout) begin
            r_err <= 1'b1;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ifu_gnt_o    = w_ifu_gnt;
  assign bus.lsu_gnt_o    = w_lsu_gnt;
  assign bus.ifu_rvalid_o = w_rvalid & ~r_owner_lsu;
  assign bus.lsu_rvalid_o = w_rvalid & r_owner_lsu;
  assign bus.ifu_rdata_o  = (w_rvalid & ~r_owner_lsu) ? w_rdata : 32'h0;
  assign bus.lsu_rdata_o  = (w_rvalid & r_owner_lsu) ? w_rdata : 32'h0;
  assign bus.ifu_err_o    = w_rvalid & ~r_owner_lsu & r_err;
  assign bus.lsu_err_o    = w_rvalid & r_owner_lsu & r_err;
  assign bus.ram_en_o     = w_ram_en;
  assign bus.ram_we_o     = w_ram_we;
  assign bus.ram_addr_o   = w_ram_addr;
  assign bus.ram_wdata_o  = w_ram_wdata;
  assign bus.io_en_o      = w_io_en;
  assign bus.io_we_o      = w_io_we;
  assign bus.io_addr_o    = w_io_addr;
  assign bus.io_wdata_o   = w_io_wdata;

endmodule
